axis_uart_tx: RTL and testbench
===============================

Name: axis_uart_tx

Overview:
- UART transmitter. Accepts bytes on an AXI4-Stream slave port and serialises each one onto the tx line.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits (1).
- Sits in the AXIS–UART bridge as the transmit path, opposite the UART receiver.
- A one-entry holding register lets the next byte be accepted while the current frame shifts, so frames go out back-to-back.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD, integer division. CLK_FREQ/BAUD >= 2 is required.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_BITS  byte to transmit.
- s_axis_tvalid  in  1  tdata valid.
- s_axis_tready  out  1  holding register free.
- tx  out  1  UART serial output; idles high.
- tx_busy  out  1  high while a frame is on the line or a byte is held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state is updated on posedge clk; rst_n low clears it immediately, without waiting for a clock edge.
- Reset values: tx=1, s_axis_tready=1, tx_busy=0, FSM=IDLE, all counters 0, holding register empty.
- Handshake:
  - Transfer occurs on a rising edge where s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !hold_valid, registered. It never depends combinationally on tvalid.
  - tdata is captured into hold_data; hold_valid is set.
- Holding register:
  - Cleared on the cycle the FSM loads it into the shifter.
  - Once hold_valid is cleared, tready rises the next cycle, so a new byte can be accepted during the current frame.
- Baud timing:
  - Counter baud_cnt is $clog2(BAUD_DIV)+1 bits wide. It counts 0..BAUD_DIV-1 and then wraps.
  - Every bit period, including start, parity and stop, is exactly BAUD_DIV clocks.
  - The counter is reset to 0 on each frame start.
- FSM states:
  - IDLE: tx=1. If hold_valid, load the shifter, clear hold_valid, set baud_cnt=0, compute parity, go to START. tx goes 0 on the same edge.
  - START: tx=0 for BAUD_DIV clocks, then go to DATA with bit_cnt=0.
  - DATA: tx=shift[0]. At baud_cnt==BAUD_DIV-1, shift right. After bit DATA_BITS-1, go to PAR if PARITY!=0, else STOP.
  - PAR: tx = odd ? ~^data : ^data, held for one bit period, then go to STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV clocks. At the end: if hold_valid, load and go directly to START (zero idle gap); else go to IDLE.
- Latency: handshake on edge N while IDLE means hold_valid at N, load at N+1, tx low from edge N+1. Handshake-to-start-bit is 1 clock.
- tx is driven from a register, so it is glitch-free.
- tx_busy = (state!=IDLE) || hold_valid.
- Boundary conditions:
  - tvalid held high continuously: frames stream back-to-back; each frame lasts (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV clocks exactly.
  - tdata changes while tready=0: ignored.
  - Handshake on the same edge as a load from hold: permitted. The old hold value goes to the shifter and the new byte is written to hold. hold_valid stays 1 and tready stays 0.
  - rst_n asserted mid-frame: tx returns to 1 immediately and the in-flight and held bytes are discarded. After release, the next frame starts only on a new handshake.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings: IDLE, START, DATA, PAR, STOP.
  - PARITY encodings: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - BAUD_DIV computation function.
  - These are the same state encodings and baud function used by the receive path.
- One sub-module is natural: uart_baud_gen.
  - Inputs: clk, rst_n, clear.
  - Output: tick, one clock wide when the count reaches BAUD_DIV-1.
  - Reusable by the receiver.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10, unless noted):
- Reset: rst_n=0 then released -> tx=1, tready=1, tx_busy=0; no tx edges for 200 clocks with tvalid=0.
- Single byte 0x55 (8N1) -> tx low 1 clock after handshake. Line pattern start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each level lasts exactly 10 clocks; frame is 100 clocks; tx_busy falls after the stop bit.
- Back-to-back: tvalid held high with 0xA3, 0x0F, 0xFF -> second handshake occurs during the first frame. Start bits fall at t0, t0+100 and t0+200, with no idle gap. Decoding with the reference receiver model yields A3, 0F, FF.
- Parity/stop variants:
  - PARITY=2, STOP_BITS=2, byte 0x07 -> parity bit 1; frame is 120 clocks.
  - PARITY=1, byte 0x07 -> parity bit 0.
- Backpressure: tvalid asserted continuously with a changing tdata while tready=0 -> only bytes present on accepting edges are transmitted; tready never stays high while hold_valid=1.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x00 -> tx=1 asynchronously, before the next clock edge. After release, no frame is emitted until a new handshake; the next byte 0x81 then transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths:
// FSM state encodings, parity modes and the baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/axis_uart_tx_if.sv
// AXI4-Stream byte channel feeding the UART transmitter.
interface axis_uart_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses tick on the last count.
module uart_baud_gen #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int             CW   = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// UART transmitter with an AXI4-Stream input and a one-entry holding register
// so the next byte can be accepted while the current frame shifts out.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_uart_tx_if.slave        s_axis,
    output logic                 tx,
    output logic                 tx_busy
);
    localparam int             BAUD_DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 load;
    logic                 tick;

    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_valid, hold_valid_next;
    logic                 tready_q;
    logic                 accept;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .tick  (tick)
    );

    assign accept          = s_axis.tvalid && tready_q;
    assign hold_valid_next = accept || (hold_valid && !load);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        par_next      = par_bit;
        tx_next       = tx;
        load          = 1'b0;

        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                load    = hold_valid;
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_next = PAR;
                            tx_next    = par_bit;
                        end else begin
                            state_next    = STOP;
                            stop_cnt_next = 1'b0;
                            tx_next       = 1'b1;
                        end
                    end else begin
                        shift_next   = shift >> 1;
                        bit_cnt_next = bit_cnt + BW'(1);
                        tx_next      = shift_next[0];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        // A held byte restarts immediately for a gapless stream.
                        if (hold_valid) load = 1'b1;
                        else            state_next = IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            state_next = START;
            shift_next = hold_data;
            par_next   = parity_of(hold_data);
            tx_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            par_bit  <= par_next;
            tx       <= tx_next;
        end
    end

    // tready mirrors the next hold state, so it is never high while a byte is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            tready_q   <= 1'b1;
        end else begin
            if (accept) hold_data <= s_axis.tdata;
            hold_valid <= hold_valid_next;
            tready_q   <= !hold_valid_next;
        end
    end

    assign s_axis.tready = tready_q;
    assign tx_busy       = (state != IDLE) || hold_valid;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx: 8N1, 8E2 and 8O1 instances at BAUD_DIV=10,
// table-driven single frames plus streaming, backpressure and reset sequences.
module tb_axis_uart_tx;

    typedef struct {
        string      name;
        int         dut;
        logic [7:0] data;
        int         nper;
        logic [11:0] lvl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    axis_uart_tx_if #(.W(8)) if0 ();
    axis_uart_tx_if #(.W(8)) if1 ();
    axis_uart_tx_if #(.W(8)) if2 ();

    logic tx0, tx1, tx2, busy0, busy1, busy2;

    axis_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(if0), .tx(tx0), .tx_busy(busy0));
    axis_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(if1), .tx(tx1), .tx_busy(busy1));
    axis_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis(if2), .tx(tx2), .tx_busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t       vecs[6];
    logic [7:0] b2b_data[3] = '{8'hA3, 8'h0F, 8'hFF};
    logic       samp[$];
    int         samp_cyc[$];
    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    logic       rx_stop[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic tx_of(input int d);
        case (d)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic ready_of(input int d);
        case (d)
            0:       return if0.tready;
            1:       return if1.tready;
            default: return if2.tready;
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] data);
        case (d)
            0:       begin if0.tvalid = v; if0.tdata = data; end
            1:       begin if1.tvalid = v; if1.tdata = data; end
            default: begin if2.tvalid = v; if2.tdata = data; end
        endcase
    endtask

    // Reference 8N1 receiver: finds a start edge, samples each bit mid-period.
    task automatic decode();
        int i;
        logic [7:0] b;
        rx_bytes.delete();
        rx_start.delete();
        rx_stop.delete();
        i = 1;
        while (i + 95 < samp.size()) begin
            if (samp[i-1] == 1'b1 && samp[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = samp[i + 10*(j+1) + 5];
                rx_bytes.push_back(b);
                rx_start.push_back(samp_cyc[i]);
                rx_stop.push_back(samp[i + 95]);
                i += 96;
            end else begin
                i++;
            end
        end
    endtask

    // One frame: handshake, then every clock of every bit period is compared.
    task automatic do_frame(input vec_t v);
        int   ok;
        logic busy_last;
        busy_last = 1'b0;
        @(negedge clk);
        drive(v.dut, 1'b1, v.data);
        check($sformatf("%s ready before handshake", v.name), ready_of(v.dut), 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(v.dut, 1'b0, 8'h00);
        check($sformatf("%s tx idle on handshake cycle", v.name), tx_of(v.dut), 1'b1);
        check($sformatf("%s busy while held", v.name), busy_of(v.dut), 1'b1);
        for (int p = 0; p < v.nper; p++) begin
            ok = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (tx_of(v.dut) === v.lvl[p]) ok++;
                if (p == v.nper - 1 && k == 9) busy_last = busy_of(v.dut);
            end
            check($sformatf("%s period %0d clocks at level %0b", v.name, p, v.lvl[p]), ok, 10);
        end
        check($sformatf("%s busy in last stop clock", v.name), busy_last, 1'b1);
        @(negedge clk);
        check($sformatf("%s tx idle after frame", v.name), tx_of(v.dut), 1'b1);
        check($sformatf("%s busy cleared after frame", v.name), busy_of(v.dut), 1'b0);
    endtask

    initial begin
        int         edges;
        int         lows;
        int         hs[3];
        logic       prev;
        logic [7:0] acc[$];
        logic       was_acc;

        vecs[0] = '{"8N1 0x55", 0, 8'h55, 10, 12'h2AA};
        vecs[1] = '{"8N1 0xC3", 0, 8'hC3, 10, 12'h386};
        vecs[2] = '{"8E2 0x07", 1, 8'h07, 12, 12'hE0E};
        vecs[3] = '{"8O1 0x07", 2, 8'h07, 11, 12'h40E};
        vecs[4] = '{"8O1 0x00", 2, 8'h00, 11, 12'h600};
        vecs[5] = '{"8N1 0x81 after reset", 0, 8'h81, 10, 12'h302};

        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);

        // Reset state and a quiet line afterwards.
        repeat (3) @(negedge clk);
        check("reset tx", tx0, 1'b1);
        check("reset tready", if0.tready, 1'b1);
        check("reset busy", busy0, 1'b0);
        check("reset tx 8E2", tx1, 1'b1);
        check("reset tx 8O1", tx2, 1'b1);
        rst_n = 1'b1;
        edges = 0;
        prev  = tx0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx0 !== prev) edges++;
            prev = tx0;
        end
        check("idle tx edges in 200 clocks", edges, 0);
        check("idle tready", if0.tready, 1'b1);
        check("idle busy", busy0, 1'b0);

        for (int i = 0; i < 5; i++) do_frame(vecs[i]);

        // Streaming: tvalid stays high across three bytes.
        repeat (5) @(negedge clk);
        samp.delete();
        samp_cyc.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int w;
                    w = 0;
                    drive(0, 1'b1, b2b_data[k]);
                    while (!ready_of(0) && w < 300) begin
                        @(negedge clk);
                        w++;
                    end
                    check($sformatf("b2b handshake %0d within budget", k), w < 300, 1'b1);
                    @(posedge clk);
                    @(negedge clk);
                    hs[k] = cyc;
                end
                drive(0, 1'b0, 8'h00);
            end
            begin
                for (int i = 0; i < 340; i++) begin
                    @(negedge clk);
                    samp.push_back(tx0);
                    samp_cyc.push_back(cyc);
                end
            end
        join
        decode();
        check("b2b frame count", rx_bytes.size(), 3);
        check("b2b second handshake 2 clocks after first", hs[1] - hs[0], 2);
        check("b2b third handshake one frame later", hs[2] - hs[1], 100);
        if (rx_start.size() > 0)
            check("b2b first start 1 clock after handshake", rx_start[0] - hs[0], 1);
        for (int k = 0; k < 3 && k < rx_bytes.size(); k++) begin
            check($sformatf("b2b byte %0d", k), rx_bytes[k], b2b_data[k]);
            check($sformatf("b2b stop %0d", k), rx_stop[k], 1'b1);
            if (k > 0)
                check($sformatf("b2b start %0d spacing", k), rx_start[k] - rx_start[0], 100 * k);
        end

        // Backpressure: tdata changes every clock while tvalid stays high.
        repeat (20) @(negedge clk);
        samp.delete();
        samp_cyc.delete();
        acc.delete();
        was_acc = 1'b0;
        for (int k = 0; k < 230; k++) begin
            if (k > 0) @(negedge clk);
            if (was_acc)
                check($sformatf("bp tready low after accept at clock %0d", k), if0.tready, 1'b0);
            drive(0, k < 50, 8'h30 + 8'(k));
            samp.push_back(tx0);
            samp_cyc.push_back(cyc);
            was_acc = (k < 50) && if0.tready;
            if (was_acc) acc.push_back(8'h30 + 8'(k));
        end
        decode();
        check("bp accepted count", acc.size(), 2);
        if (acc.size() > 1) begin
            check("bp first accepted byte", acc[0], 8'h30);
            check("bp second accepted byte", acc[1], 8'h32);
        end
        check("bp transmitted frame count", rx_bytes.size(), 2);
        if (rx_bytes.size() > 1) begin
            check("bp first transmitted byte", rx_bytes[0], 8'h30);
            check("bp second transmitted byte", rx_bytes[1], 8'h32);
        end

        // Reset during data bit 3 of 0x00.
        repeat (20) @(negedge clk);
        drive(0, 1'b1, 8'h00);
        check("mid-reset ready", if0.tready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (45) @(negedge clk);
        check("mid-reset tx low in bit 3", tx0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset tx high before next edge", tx0, 1'b1);
        check("mid-reset tready", if0.tready, 1'b1);
        check("mid-reset busy", busy0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
        end
        check("post-reset line quiet", lows, 0);
        check("post-reset busy", busy0, 1'b0);
        do_frame(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
